// File: rtl/bath_event_timer.sv
// Multi-channel bathysphere arrive/depart qualifier. Each request must hold for
// a programmable number of prescaler ticks before its output asserts.
module bath_event_timer #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 4,
   parameter int TICK_DIV = 50000000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2*NUM_CH-1:0]        req,
   input  logic [CNT_W-1:0]           delay,
   input  logic [$clog2(NUM_CH)-1:0]  sel,
   output logic [NUM_CH-1:0]          departing,
   output logic [NUM_CH-1:0]          arriving,
   output logic [NUM_CH-1:0]          busy,
   output logic [NUM_CH-1:0]          fault,
   output logic [CNT_W-1:0]           seconds,
   output logic                       tick
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ACTIVE, S_FAULT} state_t;

   logic [PRE_W-1:0] r_pre;
   logic             w_tick;

   state_t           r_state     [NUM_CH];
   state_t           w_state_nxt [NUM_CH];
   logic [1:0]       r_dir       [NUM_CH];
   logic [1:0]       w_dir_nxt   [NUM_CH];
   logic [CNT_W-1:0] r_lim       [NUM_CH];
   logic [CNT_W-1:0] w_lim_nxt   [NUM_CH];
   logic [CNT_W-1:0] r_cnt       [NUM_CH];
   logic [CNT_W-1:0] w_cnt_nxt   [NUM_CH];

   logic [NUM_CH-1:0] r_dep, r_arr, r_busy, r_fault;
   logic [NUM_CH-1:0] w_dep, w_arr, w_busy, w_fault;
   logic [CNT_W-1:0]  w_sec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                r_pre <= '0;
      else if (r_pre == PRE_TOP) r_pre <= '0;
      else                       r_pre <= r_pre + PRE_W'(1);
   end

   // Gated by reset so a TICK_DIV of 1 still shows no tick while held in reset.
   assign w_tick = reset & (r_pre == PRE_TOP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_state[c] <= S_IDLE;
            r_dir[c]   <= '0;
            r_lim[c]   <= '0;
            r_cnt[c]   <= '0;
         end
         r_dep   <= '0;
         r_arr   <= '0;
         r_busy  <= '0;
         r_fault <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_state[c] <= w_state_nxt[c];
            r_dir[c]   <= w_dir_nxt[c];
            r_lim[c]   <= w_lim_nxt[c];
            r_cnt[c]   <= w_cnt_nxt[c];
         end
         r_dep   <= w_dep;
         r_arr   <= w_arr;
         r_busy  <= w_busy;
         r_fault <= w_fault;
      end
   end

   // Event priority: conflict, release, direction change / start, tick.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_state_nxt[c] = r_state[c];
         w_dir_nxt[c]   = r_dir[c];
         w_lim_nxt[c]   = r_lim[c];
         w_cnt_nxt[c]   = r_cnt[c];
         if (req[2*c +: 2] == 2'b11) begin
            w_state_nxt[c] = S_FAULT;
            w_cnt_nxt[c]   = '0;
         end else if (req[2*c +: 2] == 2'b00) begin
            w_state_nxt[c] = S_IDLE;
            w_cnt_nxt[c]   = '0;
         end else if (r_state[c] == S_FAULT) begin
            w_state_nxt[c] = S_FAULT;
         end else if ((r_state[c] == S_IDLE) || (req[2*c +: 2] != r_dir[c])) begin
            w_dir_nxt[c]   = req[2*c +: 2];
            w_lim_nxt[c]   = delay;
            w_cnt_nxt[c]   = '0;
            w_state_nxt[c] = (delay == '0) ? S_ACTIVE : S_COUNT;
         end else if ((r_state[c] == S_COUNT) && w_tick && (r_cnt[c] < r_lim[c])) begin
            w_cnt_nxt[c] = r_cnt[c] + CNT_W'(1);
            if ((r_cnt[c] + CNT_W'(1)) == r_lim[c]) w_state_nxt[c] = S_ACTIVE;
         end
      end
   end

   always_comb begin
      w_dep   = '0;
      w_arr   = '0;
      w_busy  = '0;
      w_fault = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_arr[c]   = (w_state_nxt[c] == S_ACTIVE) && (w_dir_nxt[c] == 2'b01);
         w_dep[c]   = (w_state_nxt[c] == S_ACTIVE) && (w_dir_nxt[c] == 2'b10);
         w_busy[c]  = (w_state_nxt[c] == S_COUNT);
         w_fault[c] = (w_state_nxt[c] == S_FAULT);
      end
   end

   always_comb begin
      w_sec = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel == SEL_W'(c)) w_sec = r_cnt[c];
      end
   end

   assign departing = r_dep;
   assign arriving  = r_arr;
   assign busy      = r_busy;
   assign fault     = r_fault;
   assign seconds   = w_sec;
   assign tick      = w_tick;

endmodule

// File: tb/tb_bath_event_timer.sv
// Directed bench for bath_event_timer: one instance with TICK_DIV=1, one with
// TICK_DIV=4, sharing the clock and reset.
module tb_bath_event_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] reqA, reqB;
   logic [3:0] delayA, delayB;
   logic       selA, selB;
   logic [1:0] depA, arrA, busyA, faultA;
   logic [1:0] depB, arrB, busyB, faultB;
   logic [3:0] secA, secB;
   logic       tickA, tickB;

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   bath_event_timer #(.NUM_CH(2), .CNT_W(4), .TICK_DIV(1)) u_a (
      .clk(clk), .reset(reset), .req(reqA), .delay(delayA), .sel(selA),
      .departing(depA), .arriving(arrA), .busy(busyA), .fault(faultA),
      .seconds(secA), .tick(tickA));

   bath_event_timer #(.NUM_CH(2), .CNT_W(4), .TICK_DIV(4)) u_b (
      .clk(clk), .reset(reset), .req(reqB), .delay(delayB), .sel(selB),
      .departing(depB), .arriving(arrB), .busy(busyB), .fault(faultB),
      .seconds(secB), .tick(tickB));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ticks;
      int gap;
      int found;
      logic [1:0] acc;

      reset = 1'b0; reqA = '0; delayA = '0; selA = 1'b0;
      reqB = '0; delayB = '0; selB = 1'b0;
      step(3);
      chk("rst_busyA",  busyA,  0);
      chk("rst_faultA", faultA, 0);
      chk("rst_arrA",   arrA,   0);
      chk("rst_depA",   depA,   0);
      chk("rst_secA",   secA,   0);
      chk("rst_tickA",  tickA,  0);
      chk("rst_tickB",  tickB,  0);
      reset = 1'b1;
      step(1);

      // Arrival after 5 ticks; a delay change mid-count must be ignored
      delayA = 5; reqA = 4'b0001;
      step(1);
      chk("a_busy", busyA, 2'b01);
      chk("a_sec0", secA, 0);
      delayA = 2;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk("a_sec", secA, k);
         chk("a_arr", arrA, (k == 5) ? 2'b01 : 2'b00);
      end
      chk("a_busy_end", busyA, 0);
      chk("a_ch1_quiet", {depA[1], arrA[1], busyA[1], faultA[1]}, 0);
      reqA = 4'b0000;
      step(1);
      chk("a_rel_arr", arrA, 0);
      chk("a_rel_sec", secA, 0);

      // Departure request dropped before qualification
      delayA = 5; reqA = 4'b0010;
      step(4);
      chk("d_sec3", secA, 3);
      chk("d_busy", busyA, 2'b01);
      reqA = 4'b0000;
      step(1);
      chk("d_drop_busy", busyA, 0);
      chk("d_drop_sec", secA, 0);
      step(6);
      chk("d_never_dep", depA, 0);

      // Direction switch while active restarts the count
      reqA = 4'b0001;
      step(6);
      chk("s_arr", arrA, 2'b01);
      reqA = 4'b0010;
      step(1);
      chk("s_arr_off", arrA, 0);
      chk("s_busy", busyA, 2'b01);
      chk("s_sec0", secA, 0);
      step(4);
      chk("s_sec4", secA, 4);
      chk("s_dep_early", depA, 0);
      step(1);
      chk("s_dep", depA, 2'b01);
      chk("s_sec5", secA, 5);
      reqA = 4'b0000;
      step(1);

      // Conflict on channel 1
      selA = 1'b1; delayA = 5; reqA = 4'b0100;
      step(3);
      chk("f_busy", busyA, 2'b10);
      chk("f_sec2", secA, 2);
      reqA = 4'b1100;
      step(1);
      chk("f_fault", faultA, 2'b10);
      chk("f_busy_off", busyA, 0);
      chk("f_sec0", secA, 0);
      reqA = 4'b0100;
      step(3);
      chk("f_hold", faultA, 2'b10);
      chk("f_hold_busy", busyA, 0);
      chk("f_hold_arr", arrA, 0);
      reqA = 4'b0000;
      step(1);
      chk("f_clear", faultA, 0);
      selA = 1'b0;

      // TICK_DIV=4: zero delay qualifies on the next edge
      delayB = 0; reqB = 4'b0001;
      step(1);
      chk("b_arr_d0", arrB, 2'b01);
      reqB = 4'b0000;
      step(1);
      chk("b_arr_off", arrB, 0);

      found = 0;
      for (int i = 0; i < 8 && found == 0; i++) begin
         if (tickB) found = 1;
         else step(1);
      end
      chk("b_tick_seen", found, 1);
      gap = 0;
      found = 0;
      for (int i = 0; i < 8 && found == 0; i++) begin
         step(1);
         gap++;
         if (tickB) found = 1;
      end
      chk("b_tick_period", gap, 4);

      delayB = 3; reqB = 4'b0001;
      step(1);
      chk("b_busy", busyB, 2'b01);
      ticks = 0;
      for (int i = 0; i < 14; i++) begin
         if (tickB) ticks++;
         step(1);
         chk("b_arr_d3", arrB, (ticks >= 3) ? 2'b01 : 2'b00);
      end
      reqB = 4'b0000;

      // Reset mid-count on both channels
      delayA = 9; reqA = 4'b1001;
      step(3);
      chk("r_busy_both", busyA, 2'b11);
      chk("r_sec2", secA, 2);
      reset = 1'b0;
      #1;
      chk("r_busy0", busyA, 0);
      chk("r_arr0", arrA, 0);
      chk("r_dep0", depA, 0);
      chk("r_fault0", faultA, 0);
      chk("r_sec0", secA, 0);
      chk("r_tick0", tickA, 0);
      reqA = 4'b0000;
      step(1);
      reset = 1'b1;
      acc = '0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         acc = acc | arrA | depA | busyA;
      end
      chk("r_quiet", acc, 0);
      delayA = 2; reqA = 4'b0001;
      step(3);
      chk("r_reapply", arrA, 2'b01);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
